// File: rtl/noise_block_streamer.sv
// Frame/block sequencer feeding the noise estimator: slices a sample stream into blocks and
// emits framing strobes. Optional block_done watchdog enabled by defining NBS_TIMEOUT_EN.
module noise_block_streamer #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TOTAL_SAMPLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic [31:0]           blocks_per_frame,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  start_of_frame,
    output logic                  start_of_data,
    output logic                  end_of_frame,
    input  logic                  block_done,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int unsigned CntW = $clog2(TOTAL_SAMPLES);

    typedef enum logic [2:0] {
        StIdle,
        StSof,
        StStream,
        StWaitDone,
        StEof
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       sample_cnt_q, sample_cnt_d;
    logic [31:0]           block_cnt_q, block_cnt_d;
    logic [31:0]           blocks_q, blocks_d;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  data_valid_q;
    logic                  sod_q;
    logic                  handshake;
    logic                  last_sample;
    logic                  wd_expire;
    logic                  block_advance;

    assign handshake   = in_valid && (state_q == StStream);
    assign last_sample = (sample_cnt_q == CntW'(TOTAL_SAMPLES - 1));

`ifdef NBS_TIMEOUT_EN
    logic [31:0] wd_cnt_q;
    logic        timeout_q;

    assign wd_expire = (state_q == StWaitDone) && !block_done &&
                       (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1));

    // Counter only runs inside WAIT_DONE, so every entry starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q <= (state_q == StWaitDone) ? wd_cnt_q + 32'd1 : 32'd0;
            if (wd_expire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_q;
`else
    assign wd_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign block_advance = block_done || wd_expire;

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        block_cnt_d  = block_cnt_q;
        blocks_d     = blocks_q;
        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    blocks_d    = blocks_per_frame;
                    block_cnt_d = '0;
                    state_d     = StSof;
                end
            end
            StSof: begin
                state_d = (blocks_q == 32'd0) ? StEof : StStream;
            end
            StStream: begin
                if (handshake) begin
                    if (last_sample) begin
                        sample_cnt_d = '0;
                        state_d      = StWaitDone;
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
            end
            StWaitDone: begin
                if (block_advance) begin
                    block_cnt_d = block_cnt_q + 32'd1;
                    state_d     = (block_cnt_d == blocks_q) ? StEof : StStream;
                end
            end
            StEof: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            sample_cnt_q <= '0;
            block_cnt_q  <= '0;
            blocks_q     <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            sod_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            block_cnt_q  <= block_cnt_d;
            blocks_q     <= blocks_d;
            data_valid_q <= handshake;
            sod_q        <= handshake && (sample_cnt_q == '0);
            if (handshake) begin
                data_out_q <= in_data;
            end
        end
    end

    // Strobes are pure state decodes so in_ready has no path from in_valid.
    assign in_ready       = (state_q == StStream);
    assign start_of_frame = (state_q == StSof);
    assign end_of_frame   = (state_q == StEof);
    assign busy           = (state_q != StIdle);
    assign data_out       = data_out_q;
    assign data_valid     = data_valid_q;
    assign start_of_data  = sod_q;

endmodule

// File: tb/tb_noise_block_streamer.sv
// Directed self-checking bench for noise_block_streamer; timeout branch follows NBS_TIMEOUT_EN.
module tb_noise_block_streamer;

    localparam int TS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic [31:0] blocks_per_frame = '0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        start_of_frame;
    logic        start_of_data;
    logic        end_of_frame;
    logic        block_done = 1'b0;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int failures = 0;
    int beats, sod_cnt, sof_cnt, eof_cnt;
    int done_delay = -1;
    int done_wait = -1;
    bit valid_toggle = 1'b0;
    logic [7:0] src = '0;
    logic [7:0] exp_out = '0;

    noise_block_streamer #(
        .DATA_WIDTH     (8),
        .TOTAL_SAMPLES  (TS),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .frame_start      (frame_start),
        .blocks_per_frame (blocks_per_frame),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .data_out         (data_out),
        .data_valid       (data_valid),
        .start_of_frame   (start_of_frame),
        .start_of_data    (start_of_data),
        .end_of_frame     (end_of_frame),
        .block_done       (block_done),
        .busy             (busy),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: update the source model, drive inputs, then observe outputs #1 after the edge.
    task automatic tick();
        logic hs;
        hs = in_valid && in_ready && !rst;
        @(posedge clk);
        #1;
        if (hs) src = src + 8'd1;
        in_data    = src;
        block_done = 1'b0;
        if (valid_toggle) in_valid = ~in_valid;
        if (done_wait > 0) begin
            done_wait--;
        end else if (done_wait == 0) begin
            block_done = 1'b1;
            done_wait  = -1;
        end
        if (start_of_frame) sof_cnt++;
        if (end_of_frame) eof_cnt++;
        if (start_of_data) sod_cnt++;
        if (data_valid) begin
            check("data_order", data_out, exp_out);
            check("sod_pos", start_of_data, (beats % TS) == 0);
            exp_out = exp_out + 8'd1;
            beats++;
            check("ready_at_beat", in_ready, (beats % TS) != 0);
            if ((beats % TS) == 0 && done_delay >= 0) done_wait = done_delay;
        end
    endtask

    task automatic reset_stats();
        beats   = 0;
        sod_cnt = 0;
        sof_cnt = 0;
        eof_cnt = 0;
    endtask

    task automatic start_frame(input logic [31:0] n);
        blocks_per_frame = n;
        frame_start      = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic run_to_idle(input int max);
        int n;
        n = 0;
        while (busy && n < max) begin
            tick();
            n++;
        end
        check("frame_bound", n < max, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_data_out"}, data_out, 0);
        check({tag, "_data_valid"}, data_valid, 0);
        check({tag, "_sof"}, start_of_frame, 0);
        check({tag, "_sod"}, start_of_data, 0);
        check({tag, "_eof"}, end_of_frame, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_timeout"}, timeout_err, 0);
    endtask

    initial begin
        int n;
        int w;
        reset_stats();
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Basic frame: 4 blocks, continuous valid, block_done a few cycles after each block.
        reset_stats();
        in_valid   = 1'b1;
        done_delay = 2;
        start_frame(4);
        check("sof_strobe", start_of_frame, 1);
        check("ready_in_sof", in_ready, 0);
        check("busy_in_sof", busy, 1);
        tick();
        check("sof_one_cycle", start_of_frame, 0);
        check("ready_after_sof", in_ready, 1);
        run_to_idle(400);
        check("basic_beats", beats, 64);
        check("basic_sod", sod_cnt, 4);
        check("basic_sof", sof_cnt, 1);
        check("basic_eof", eof_cnt, 1);
        check("basic_eof_low", end_of_frame, 0);

        // Toggling valid, one block.
        reset_stats();
        valid_toggle = 1'b1;
        done_delay   = 0;
        start_frame(1);
        run_to_idle(200);
        valid_toggle = 1'b0;
        in_valid     = 1'b1;
        check("gap_beats", beats, 16);
        check("gap_sod", sod_cnt, 1);
        check("gap_eof", eof_cnt, 1);

        // Zero blocks: SOF and EOF back to back.
        reset_stats();
        done_delay = -1;
        start_frame(0);
        check("zero_sof", start_of_frame, 1);
        check("zero_busy0", busy, 1);
        tick();
        check("zero_eof", end_of_frame, 1);
        check("zero_sof_low", start_of_frame, 0);
        check("zero_busy1", busy, 1);
        tick();
        check("zero_idle", busy, 0);
        check("zero_eof_low", end_of_frame, 0);
        check("zero_beats", beats, 0);

        // Spurious block_done mid-stream and frame_start mid-frame are ignored.
        reset_stats();
        done_delay = 1;
        start_frame(4);
        repeat (5) tick();
        block_done = 1'b1;
        tick();
        frame_start      = 1'b1;
        blocks_per_frame = 7;
        tick();
        frame_start = 1'b0;
        run_to_idle(400);
        check("spur_beats", beats, 64);
        check("spur_sod", sod_cnt, 4);
        check("spur_sof", sof_cnt, 1);
        check("spur_eof", eof_cnt, 1);
        tick();
        check("spur_no_restart", busy, 0);

        // Reset after 7 samples of the third block, then a clean frame.
        reset_stats();
        done_delay = 0;
        start_frame(4);
        n = 0;
        while (beats < 39 && n < 300) begin
            tick();
            n++;
        end
        check("rst_mid_bound", n < 300, 1);
        rst = 1'b1;
        tick();
        check_all_zero("rst_mid");
        rst = 1'b0;
        tick();
        reset_stats();
        start_frame(4);
        run_to_idle(400);
        check("after_rst_beats", beats, 64);
        check("after_rst_sod", sod_cnt, 4);
        check("after_rst_eof", eof_cnt, 1);

        // block_done never arrives.
        reset_stats();
        done_delay = -1;
        start_frame(2);
        n = 0;
        while (beats < 16 && n < 100) begin
            tick();
            n++;
        end
        check("to_first_block", beats, 16);
`ifdef NBS_TIMEOUT_EN
        w = 0;
        while (!in_ready && w < 200) begin
            w++;
            tick();
        end
        check("to_wait_cycles", w, 8);
        check("to_err_set", timeout_err, 1);
        check("to_busy", busy, 1);
        done_delay = 0;
        run_to_idle(200);
        check("to_err_sticky", timeout_err, 1);
`else
        w = 0;
        repeat (100) begin
            tick();
            if (!in_ready && busy && !timeout_err) w++;
        end
        check("no_to_wait", w, 100);
        check("no_to_err", timeout_err, 0);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("final_err_clear", timeout_err, 0);
        check("final_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
